mem_fifo_ctrl: RTL and testbench

//  Upstream access controller that turns a push/pop byte stream into write/read cycles on the 8-byte memory chip.

---
 rtl/mem_fifo_pkg.sv | 14 +
 rtl/mem_fifo_if.sv | 32 +++
 rtl/mem_fifo_arb.sv | 27 ++
 rtl/memory_8byte.sv | 24 ++
 rtl/mem_fifo_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_fifo_ctrl.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_fifo_pkg.sv
// Shared constants for the memory-backed FIFO controller: default geometry and FSM encoding.
package mem_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH_DEF  = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WR   = 2'd1;
    localparam state_t ST_RD   = 2'd2;

endpackage

// File: rtl/mem_fifo_if.sv
// Push/pop stream and status bundle between an upstream client (master) and mem_fifo_ctrl (slave).
interface mem_fifo_if
    import mem_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              PUSH;
    logic [DATA_W-1:0] PUSH_D;
    logic              PUSH_READY;
    logic              POP;
    logic              POP_READY;
    logic [DATA_W-1:0] POP_D;
    logic              POP_VALID;
    logic              FULL;
    logic              EMPTY;
    logic [ADDR_W:0]   COUNT;
    logic              OVF;
    logic              UNF;

    modport master (
        output PUSH, PUSH_D, POP,
        input  PUSH_READY, POP_READY, POP_D, POP_VALID, FULL, EMPTY, COUNT, OVF, UNF
    );

    modport slave (
        input  PUSH, PUSH_D, POP,
        output PUSH_READY, POP_READY, POP_D, POP_VALID, FULL, EMPTY, COUNT, OVF, UNF
    );

endinterface

// File: rtl/mem_fifo_arb.sv
// Two-way round-robin picker between push and pop; the last-served bit starts at "pop" so push wins first.
module mem_fifo_arb (
    input  logic CLK,
    input  logic R,
    input  logic req_push,
    input  logic req_pop,
    output logic grant_push,
    output logic grant_pop
);

    logic last_pop_reg;

    // On contention serve the kind that was not served last.
    assign grant_push = req_push & (~req_pop | last_pop_reg);
    assign grant_pop  = req_pop  & (~req_push | ~last_pop_reg);

    always_ff @(posedge CLK) begin
        if (R) begin
            last_pop_reg <= 1'b1;
        end else if (grant_push) begin
            last_pop_reg <= 1'b0;
        end else if (grant_pop) begin
            last_pop_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/memory_8byte.sv
// 8-line byte memory: writes on the clock edge ending a CS&WE cycle, combinational read data while CS&RE.
module memory_8byte
    import mem_fifo_pkg::*;
(
    input  logic                  CLK,
    input  logic                  CS,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [ADDR_W_DEF-1:0] A,
    input  logic [DATA_W_DEF-1:0] D,
    output logic [DATA_W_DEF-1:0] out
);

    logic [DATA_W_DEF-1:0] mem_arr [DEPTH_DEF];

    always_ff @(posedge CLK) begin
        if (CS & WE) begin
            mem_arr[A] <= D;
        end
    end

    assign out = (CS & RE) ? mem_arr[A] : '0;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Turns a push/pop byte stream into single-cycle write/read accesses on an 8-line memory, forming an 8-deep FIFO.
// Optional sticky OVF/UNF error flags are built only when MEM_FIFO_ERR_EN is defined.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              R,
    mem_fifo_if.slave         strm,
    output logic              MEM_CS,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [DATA_W-1:0] MEM_D,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [DATA_W-1:0] MEM_Q
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg;
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [DATA_W-1:0] wbuf_reg;
    logic [DATA_W-1:0] pop_d_reg;
    logic              pop_valid_reg;
    logic              idle;
    logic              full;
    logic              empty;
    logic              push_ready;
    logic              pop_ready;
    logic              grant_push;
    logic              grant_pop;

    assign idle       = (state_reg == ST_IDLE);
    assign full       = (count_reg == FULL_CNT);
    assign empty      = (count_reg == '0);
    assign push_ready = idle & ~full;
    assign pop_ready  = idle & ~empty;

    mem_fifo_arb u_arb (
        .CLK        (CLK),
        .R          (R),
        .req_push   (strm.PUSH & push_ready),
        .req_pop    (strm.POP & pop_ready),
        .grant_push (grant_push),
        .grant_pop  (grant_pop)
    );

    always_ff @(posedge CLK) begin
        if (R) begin
            state_reg     <= ST_IDLE;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            wbuf_reg      <= '0;
            pop_d_reg     <= '0;
            pop_valid_reg <= 1'b0;
        end else begin
            pop_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_push) begin
                        wbuf_reg  <= strm.PUSH_D;
                        state_reg <= ST_WR;
                    end else if (grant_pop) begin
                        state_reg <= ST_RD;
                    end
                end
                ST_WR: begin
                    wptr_reg  <= wptr_reg + 1'b1;
                    count_reg <= count_reg + 1'b1;
                    state_reg <= ST_IDLE;
                end
                ST_RD: begin
                    pop_d_reg     <= MEM_Q;
                    pop_valid_reg <= 1'b1;
                    rptr_reg      <= rptr_reg + 1'b1;
                    count_reg     <= count_reg - 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Memory pins are a pure decode of the access state, so they are all low in IDLE and after reset.
    always_comb begin
        MEM_CS = 1'b0;
        MEM_WE = 1'b0;
        MEM_RE = 1'b0;
        MEM_A  = '0;
        MEM_D  = '0;
        case (state_reg)
            ST_WR: begin
                MEM_CS = 1'b1;
                MEM_WE = 1'b1;
                MEM_A  = wptr_reg;
                MEM_D  = wbuf_reg;
            end
            ST_RD: begin
                MEM_CS = 1'b1;
                MEM_RE = 1'b1;
                MEM_A  = rptr_reg;
            end
            default: ;
        endcase
    end

    assign strm.PUSH_READY = push_ready;
    assign strm.POP_READY  = pop_ready;
    assign strm.POP_D      = pop_d_reg;
    assign strm.POP_VALID  = pop_valid_reg;
    assign strm.FULL       = full;
    assign strm.EMPTY      = empty;
    assign strm.COUNT      = count_reg;

`ifdef MEM_FIFO_ERR_EN
    logic ovf_reg;
    logic unf_reg;

    always_ff @(posedge CLK) begin
        if (R) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            if (idle & strm.PUSH & full) begin
                ovf_reg <= 1'b1;
            end
            if (idle & strm.POP & empty) begin
                unf_reg <= 1'b1;
            end
        end
    end

    assign strm.OVF = ovf_reg;
    assign strm.UNF = unf_reg;
`else
    assign strm.OVF = 1'b0;
    assign strm.UNF = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Randomized and directed bench for mem_fifo_ctrl driving memory_8byte, checked against a queue-based FIFO model.
module tb_mem_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       mem_cs;
    logic       mem_we;
    logic       mem_re;
    logic [2:0] mem_a;
    logic [7:0] mem_d;
    logic [7:0] mem_q;

    mem_fifo_if #(.DATA_W(8), .ADDR_W(3)) strm ();

    mem_fifo_ctrl dut (
        .CLK    (clk),
        .R      (rst),
        .strm   (strm),
        .MEM_CS (mem_cs),
        .MEM_A  (mem_a),
        .MEM_D  (mem_d),
        .MEM_WE (mem_we),
        .MEM_RE (mem_re),
        .MEM_Q  (mem_q)
    );

    memory_8byte u_mem (
        .CLK (clk),
        .CS  (mem_cs),
        .WE  (mem_we),
        .RE  (mem_re),
        .A   (mem_a),
        .D   (mem_d),
        .out (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: committed bytes as a queue, one operation in flight at most.
    logic [7:0] q[$];
    int         pending;      // 0 none, 1 write in progress, 2 read in progress
    logic [7:0] pend_byte;
    int         wr_total;
    int         rd_total;
    bit         last_push;
    bit         exp_valid;
    logic [7:0] exp_pop_d;
    bit         exp_ovf;
    bit         exp_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pending   = 0;
        pend_byte = '0;
        wr_total  = 0;
        rd_total  = 0;
        last_push = 1'b0;
        exp_valid = 1'b0;
        exp_pop_d = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst         = 1'b1;
        strm.PUSH   = 1'b0;
        strm.POP    = 1'b0;
        strm.PUSH_D = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count",     32'(strm.COUNT),     32'd0);
        chk("rst_empty",     32'(strm.EMPTY),     32'd1);
        chk("rst_pop_valid", 32'(strm.POP_VALID), 32'd0);
        chk("rst_mem_we",    32'(mem_we),         32'd0);
        chk("rst_ovf",       32'(strm.OVF),       32'd0);
        chk("rst_unf",       32'(strm.UNF),       32'd0);
        rst = 1'b0;
        model_reset();
        $display("reset applied");
    endtask

    // One clock: check every output against the model, drive new requests, advance the model across the edge.
    task automatic step(input logic push, input logic pop, input logic [7:0] data);
        int   n;
        logic do_push;
        logic do_pop;
        logic [31:0] exp_a;
        @(negedge clk);
        n = q.size();
        exp_a = (pending == 1) ? 32'(wr_total % 8) : (pending == 2) ? 32'(rd_total % 8) : 32'd0;
        chk("count",      32'(strm.COUNT),      32'(n));
        chk("full",       32'(strm.FULL),       32'(n == 8));
        chk("empty",      32'(strm.EMPTY),      32'(n == 0));
        chk("push_ready", 32'(strm.PUSH_READY), 32'(pending == 0 && n < 8));
        chk("pop_ready",  32'(strm.POP_READY),  32'(pending == 0 && n > 0));
        chk("pop_valid",  32'(strm.POP_VALID),  32'(exp_valid));
        chk("pop_d",      32'(strm.POP_D),      32'(exp_pop_d));
        chk("mem_we",     32'(mem_we),          32'(pending == 1));
        chk("mem_re",     32'(mem_re),          32'(pending == 2));
        chk("mem_cs",     32'(mem_cs),          32'(pending != 0));
        chk("mem_a",      32'(mem_a),           exp_a);
        chk("mem_d",      32'(mem_d),           (pending == 1) ? 32'(pend_byte) : 32'd0);
        chk("ovf",        32'(strm.OVF),        32'(exp_ovf));
        chk("unf",        32'(strm.UNF),        32'(exp_unf));
        if (exp_valid) $display("pop  data=%02h count=%0d", exp_pop_d, n);

        strm.PUSH   = push;
        strm.POP    = pop;
        strm.PUSH_D = data;

        exp_valid = 1'b0;
        if (pending == 1) begin
            q.push_back(pend_byte);
            wr_total++;
            pending = 0;
        end else if (pending == 2) begin
            exp_pop_d = q.pop_front();
            rd_total++;
            exp_valid = 1'b1;
            pending   = 0;
        end else begin
            do_push = push && n < 8;
            do_pop  = pop && n > 0;
            if (do_push && do_pop) begin
                if (last_push) do_push = 1'b0;
                else           do_pop  = 1'b0;
            end
            if (do_push) begin
                pending   = 1;
                pend_byte = data;
                last_push = 1'b1;
                $display("push data=%02h accepted", data);
            end else if (do_pop) begin
                pending   = 2;
                last_push = 1'b0;
                $display("pop  request accepted");
            end
`ifdef MEM_FIFO_ERR_EN
            if (push && n == 8) exp_ovf = 1'b1;
            if (pop && n == 0)  exp_unf = 1'b1;
`endif
        end
    endtask

    initial begin
        int push_pct;
        int pop_pct;
        rst         = 1'b1;
        strm.PUSH   = 1'b0;
        strm.POP    = 1'b0;
        strm.PUSH_D = '0;
        model_reset();
        reset_dut();

        // Latency of a single push/pop pair from a fresh reset.
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        // Reset in the middle of a write drops it.
        step(1'b1, 1'b0, 8'h5A);
        reset_dut();
        step(1'b0, 1'b0, 8'h00);

        // Fill to full, push on full, drain in order, pop on empty.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
            step(1'b0, 1'b0, 8'h00);
        end
        step(1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            step(1'b0, 1'b0, 8'h00);
        end
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        reset_dut();

        // Pointer wrap: advance both pointers to 6, then cross the 7->0 boundary.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            step(1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h00);
            step(1'b0, 1'b0, 8'h00);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 8'(i));
            step(1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00);
            step(1'b0, 1'b0, 8'h00);
        end
        step(1'b0, 1'b0, 8'h00);
        reset_dut();

        // Contention at COUNT=3 with both requests held.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'(8'hC0 + i));
            step(1'b0, 1'b0, 8'h00);
        end
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b0, 8'h00);
        reset_dut();

        // Random traffic with shifting push/pop bias so the FIFO visits full and empty.
        push_pct = 50;
        pop_pct  = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 60 == 0) begin
                push_pct = int'($urandom_range(10, 90));
                pop_pct  = int'($urandom_range(10, 90));
            end
            step(($urandom_range(0, 99) < 32'(push_pct)),
                 ($urandom_range(0, 99) < 32'(pop_pct)),
                 8'($urandom));
            if (i == 400) reset_dut();
        end
        step(1'b0, 1'b0, 8'h00);
        reset_dut();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
